scalar_product_engine: RTL
==========================

// Module: scalar_product_engine
// PURPOSE
//   Computes three signed scalar products of one streamed input vector against three
//   streamed weight vectors, one element per beat.
//   Packs the three accumulators into the 96-bit word that drives the activation LUT
//   address input (lut_module.address) directly downstream.
//   Output is held under valid/ready until the LUT stage consumes it.
// PARAMETERS
//   N       8   max elements per vector; a vector ends on s_last or on the Nth beat
//   DATA_W  8   signed width of x and weight elements
//   ACC_W   32  signed accumulator width per lane; 3*ACC_W = 96 feeds the LUT; ACC_W >= 2*DATA_W
//   CNT_W   $clog2(N+1)  element counter width (derived, not overridden)
// PORTS
//   clk      in   1         rising-edge clock
//   rst_n    in   1         asynchronous, active-low reset
//   s_valid  in   1         input beat valid
//   s_ready  out  1         engine accepts a beat; beat transfers when s_valid && s_ready
//   s_last   in   1         final element of the current vector
//   s_x      in   DATA_W    signed input element
//   s_w0     in   DATA_W    signed weight, lane 0
//   s_w1     in   DATA_W    signed weight, lane 1
//   s_w2     in   DATA_W    signed weight, lane 2
//   m_valid  out  1         result valid
//   m_ready  in   1         downstream accepts result
//   m_addr   out  3*ACC_W   {acc2, acc1, acc0}; acc0 in [ACC_W-1:0]
//   m_ovf    out  3         per-lane sticky signed-overflow flag for this result
//   m_count  out  CNT_W     number of elements accumulated into this result (1..N)
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//       state=IDLE; all accumulators, m_addr, m_ovf and m_count = 0; m_valid=0; s_ready=1.
//   - FSM states:
//       IDLE  no beat taken yet.
//       ACCUM >=1 beat taken.
//       HOLD  result presented.
//   - s_ready = (state != HOLD), i.e. s_ready = !m_valid. It is registered-state derived,
//     with no combinational path from m_ready.
//   - Accepted beat, lane i:
//       p_i = s_x * s_wi, signed, 2*DATA_W wide, sign-extended to ACC_W.
//       First beat of a vector (IDLE): acc_i <= p_i; cnt <= 1; ovf_i <= 0. No clear cycle needed.
//       Later beats: acc_i <= acc_i + p_i, wrapping modulo 2^ACC_W; cnt <= cnt + 1.
//       ovf_i sets when both addends share a sign and the sum sign differs. It stays set until
//       the next vector starts.
//   - Vector end: an accepted beat with s_last=1, or with cnt+1 == N.
//       On that beat: state -> HOLD; m_valid=1 in the next cycle (latency 1 from the last beat).
//       m_addr/m_ovf/m_count reflect that last beat included.
//       s_last on the first beat gives a 1-element result (may end directly from IDLE).
//   - HOLD:
//       m_addr, m_ovf and m_count are stable while m_valid && !m_ready.
//       s_valid is ignored (s_ready=0).
//       On m_valid && m_ready: state -> IDLE, m_valid=0 next cycle, and the first beat of the
//       next vector is accepted the cycle after. This gives one bubble per vector, by design.
//   - IDLE/ACCUM cycles with s_valid=0 leave all state unchanged; gaps are legal anywhere.
//   - Reset mid-vector or mid-HOLD aborts immediately: partial sums are discarded and no
//     result is emitted.
//   - m_addr is driven from registers only; no combinational path from inputs to m_*.
// STRUCTURE
//   - Shared package ann_pkg: DATA_W, ACC_W, N_LANES=3, the state enum (IDLE/ACCUM/HOLD),
//     and the lane-packing order constant. lut_module uses the same ACC_W/N_LANES.
//   - Sub-module mac_lane (one instance per lane, 3 total): signed multiply, first-beat load
//     vs accumulate, wrap add, sticky overflow.
//   - Top holds the FSM, cnt, handshake and output packing.
// TESTING
//   1. N=4, x={1,2,3,4}, w0={1,1,1,1}, w1={2,2,2,2}, w2={-1,-1,-1,-1}, s_last on beat 4
//      -> m_addr={32'hFFFFFFF6, 32'h00000014, 32'h0000000A}, m_count=4, m_ovf=0,
//         m_valid rises 1 cycle after beat 4.
//   2. Result from test 1, m_ready held 0 for 5 cycles
//      -> m_valid stays 1, m_addr unchanged, s_ready=0, extra s_valid beats not consumed.
//      Then m_ready=1 for one cycle -> m_valid=0 next cycle, s_ready=1.
//   3. Vector x={3,5}, w0={7,-2}, s_last on beat 2 -> acc0=11, m_count=2.
//      A 1-beat vector with s_last -> m_count=1, acc0=x*w0.
//   4. ACC_W=16, DATA_W=8, two beats x=-128, w0=-128
//      -> acc0=16'h8000 (wrapped), m_ovf[0]=1, m_ovf[2:1]=0.
//      The next vector starts with m_ovf=0.
//   5. Test 1 vector with s_valid=0 gaps of 1..3 random cycles between beats
//      -> identical m_addr and m_count to test 1.
//   6. rst_n pulsed low after 2 beats of a 4-beat vector
//      -> m_valid=0 and s_ready=1 immediately.
//      A following 4-beat vector yields only its own sums, with m_count=4.

Source files
------------

// File: rtl/ann_pkg.sv
// ---------------------------------------------------------------------------
// ann_pkg
//   Shared definitions for the scalar product engine and the activation LUT
//   stage it feeds. The LUT consumes N_LANES*ACC_W address bits, so both
//   blocks must agree on ACC_W, N_LANES and the lane packing order.
//   No ports; constants, the engine state type and a packing helper only.
// ---------------------------------------------------------------------------
package ann_pkg;

    localparam int N_DEFAULT = 8;   // max elements per vector
    localparam int DATA_W    = 8;   // signed element width
    localparam int ACC_W     = 32;  // signed accumulator width per lane
    localparam int N_LANES   = 3;   // weight vectors processed in parallel

    // Lane 0 occupies the least significant ACC_W bits of the packed word.
    localparam bit LANE0_AT_LSB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no beat of the current vector taken yet
        ACCUM = 2'd1,   // at least one beat taken
        HOLD  = 2'd2    // result presented, waiting for downstream
    } state_t;

    // Bit offset of a lane inside the packed accumulator word.
    function automatic int lane_lsb(input int lane, input int acc_w);
        return LANE0_AT_LSB ? lane * acc_w : (N_LANES - 1 - lane) * acc_w;
    endfunction

endpackage

// File: rtl/scalar_product_engine_mac_lane.sv
// ---------------------------------------------------------------------------
// mac_lane
//   One multiply-accumulate lane: signed x*w, either loaded (first beat of a
//   vector) or added to the running sum with two's-complement wrap, plus a
//   sticky signed-overflow flag that is cleared by the first-beat load.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          accepted beat this cycle
//   first       beat is the first of a vector (load instead of accumulate)
//   x, w        signed operands, DATA_W each
//   acc         registered accumulator, ACC_W
//   ovf         registered sticky overflow flag
// ---------------------------------------------------------------------------
module mac_lane #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     first,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [ACC_W-1:0]  acc,
    output logic                     ovf
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    sum;
    logic                       add_ovf;

    assign prod     = x * w;
    // Size cast of a signed operand sign-extends (also valid when ACC_W == 2*DATA_W).
    assign prod_ext = ACC_W'(prod);
    assign sum      = acc + prod_ext;
    // Overflow: operands share a sign but the wrapped sum does not.
    assign add_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            if (first) begin
                acc <= prod_ext;
                ovf <= 1'b0;
            end else begin
                acc <= sum;
                ovf <= ovf | add_ovf;
            end
        end
    end

endmodule

// File: rtl/scalar_product_engine.sv
// ---------------------------------------------------------------------------
// scalar_product_engine
//   Streams one input vector x against three weight vectors and produces the
//   three signed dot products, packed {acc2, acc1, acc0} as the activation
//   LUT address. A vector ends on s_last or on its Nth beat; the result is
//   then held under valid/ready. One idle bubble separates vectors.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_valid/s_ready/s_last  input beat handshake and end-of-vector marker
//   s_x, s_w0..s_w2         signed element and lane weights (DATA_W)
//   m_valid/m_ready         result handshake
//   m_addr                  packed accumulators, acc0 in [ACC_W-1:0]
//   m_ovf                   per-lane sticky overflow for this result
//   m_count                 elements accumulated into this result (1..N)
// ---------------------------------------------------------------------------
module scalar_product_engine #(
    parameter  int N      = ann_pkg::N_DEFAULT,
    parameter  int DATA_W = ann_pkg::DATA_W,
    parameter  int ACC_W  = ann_pkg::ACC_W,
    localparam int CNT_W  = $clog2(N + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic                             s_last,
    input  logic signed [DATA_W-1:0]         s_x,
    input  logic signed [DATA_W-1:0]         s_w0,
    input  logic signed [DATA_W-1:0]         s_w1,
    input  logic signed [DATA_W-1:0]         s_w2,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [ann_pkg::N_LANES*ACC_W-1:0] m_addr,
    output logic [ann_pkg::N_LANES-1:0]      m_ovf,
    output logic [CNT_W-1:0]                 m_count
);

    import ann_pkg::*;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               beat;
    logic               first;
    logic               vec_end;

    logic signed [DATA_W-1:0] lane_w   [N_LANES];
    logic signed [ACC_W-1:0]  lane_acc [N_LANES];

    // Handshake flags depend on registered state only, never on m_ready.
    assign s_ready  = (state_reg != HOLD);
    assign m_valid  = (state_reg == HOLD);

    assign beat     = s_valid && s_ready;
    assign first    = (state_reg == IDLE);
    assign cnt_next = first ? CNT_W'(1) : cnt_reg + CNT_W'(1);
    assign vec_end  = s_last || (cnt_next == CNT_W'(N));

    assign lane_w[0] = s_w0;
    assign lane_w[1] = s_w1;
    assign lane_w[2] = s_w2;

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            mac_lane #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_mac (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (beat),
                .first  (first),
                .x      (s_x),
                .w      (lane_w[gi]),
                .acc    (lane_acc[gi]),
                .ovf    (m_ovf[gi])
            );
            // Accumulators only change on accepted beats, so they are stable in HOLD.
            assign m_addr[lane_lsb(gi, ACC_W) +: ACC_W] = lane_acc[gi];
        end
    endgenerate

    assign m_count = cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    if (beat) begin
                        cnt_reg   <= cnt_next;
                        state_reg <= vec_end ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
